// File: rtl/mem_pkg.sv
// Shared definitions for the mem_access stage.
// Holds the datapath word type, funct3 size encodings, FSM state enum,
// and the byte-enable / store-lane helpers.
package mem_pkg;

  localparam int XLEN = 32;
  typedef logic [XLEN-1:0] word;

  // funct3 size/sign encodings (stores reuse the LB/LH/LW codes)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Byte enables for an access of the given size at the given byte offset
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_LB, F3_LBU: byte_en = 4'b0001 << off;
      F3_LH, F3_LHU: byte_en = 4'b0011 << off;
      default:       byte_en = 4'b1111;
    endcase
  endfunction

  // Store data replicated so the active lanes carry it whatever the offset
  function automatic word lane_data(input logic [2:0] f3, input word d);
    case (f3)
      F3_LB, F3_LBU: lane_data = {4{d[7:0]}};
      F3_LH, F3_LHU: lane_data = {2{d[15:0]}};
      default:       lane_data = d;
    endcase
  endfunction

  // Halfwords need addr[0]=0; words need addr[1:0]=0; bytes are always aligned
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_LB, F3_LBU: is_misaligned = 1'b0;
      F3_LH, F3_LHU: is_misaligned = off[0];
      F3_LW:         is_misaligned = (off != 2'b00);
      default:       is_misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory port of the mem_access stage.
// Handshake: the master raises mem_req with mem_we/mem_addr/mem_be/mem_wdata
// and keeps all of them constant until it samples mem_ready high on a rising
// clock edge; that edge completes the access (write accepted, or mem_rdata
// valid for a read). mem_ready is ignored while mem_req is low.
interface mem_access_if;
  import mem_pkg::*;

  logic       mem_req;
  logic       mem_we;
  word        mem_addr;
  logic [3:0] mem_be;
  word        mem_wdata;
  logic       mem_ready;
  word        mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/load_align.sv
// Load formatter: picks the byte/halfword addressed by off from the read
// word and sign- or zero-extends it according to funct3.
module load_align
  import mem_pkg::*;
(
  input  word        rdata,
  input  logic [1:0] off,
  input  logic [2:0] funct3,
  output word        data_out
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection and extension
  always_comb begin
    case (off)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   data_out = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data_out = {24'h0, byte_sel};
      F3_LH:   data_out = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data_out = {16'h0, half_sel};
      default: data_out = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: pipeline stage 4. Issues loads/stores over the memory port,
// stalls upstream while an access is outstanding, registers the result.
// Optional build macro MEM_TIMEOUT_EN adds a WAIT watchdog and bus_error.
module mem_access
  import mem_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall_in,
  input  logic            valid_in,
  input  logic            is_load,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  input  logic [4:0]      rd_in,
  mem_access_if.master    mem,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            valid_out,
  output logic            misaligned,
`ifdef MEM_TIMEOUT_EN
  output logic            bus_error,
`endif
  output logic            stall_req
);

  state_e          state_q, state_d;
  logic            req_q, req_d, we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [4:0]      rd_cap_q, rd_cap_d, rd_out_q, rd_out_d;
  logic [XLEN-1:0] buf_q, buf_d, result_q, result_d;
  logic            valid_q, valid_d, mis_q, mis_d;
  word             load_word;
  logic [XLEN-1:0] fmt;
`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             berr_q, berr_d;
`endif

  load_align u_load_align (
    .rdata    (mem.mem_rdata),
    .off      (off_q),
    .funct3   (f3_q),
    .data_out (load_word)
  );

  // Next-state and next-output logic for the access FSM
  always_comb begin
    state_d = state_q;   req_d = req_q;     we_d = we_q;
    addr_d = addr_q;     be_d = be_q;       wdata_d = wdata_q;
    f3_d = f3_q;         off_d = off_q;     rd_cap_d = rd_cap_q;
    buf_d = buf_q;       result_d = result_q;
    rd_out_d = rd_out_q; valid_d = valid_q; mis_d = mis_q;
    fmt = we_q ? '0 : load_word;
`ifdef MEM_TIMEOUT_EN
    cnt_d = cnt_q;       berr_d = berr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!stall_in) begin
          valid_d = 1'b0;
          mis_d   = 1'b0;
`ifdef MEM_TIMEOUT_EN
          berr_d  = 1'b0;
`endif
          if (valid_in) begin
            if (!is_load && !is_store) begin
              result_d = addr;
              rd_out_d = rd_in;
              valid_d  = 1'b1;
            end else if (is_misaligned(funct3, addr[1:0])) begin
              // Fault reported in place of the access; rd 0 kills writeback
              valid_d  = 1'b1;
              mis_d    = 1'b1;
              rd_out_d = 5'd0;
            end else begin
              // Load wins when both is_load and is_store are set
              req_d    = 1'b1;
              we_d     = is_store & ~is_load;
              addr_d   = {addr[XLEN-1:2], 2'b00};
              be_d     = byte_en(funct3, addr[1:0]);
              wdata_d  = lane_data(funct3, store_data);
              f3_d     = funct3;
              off_d    = addr[1:0];
              rd_cap_d = rd_in;
              state_d  = ST_WAIT;
`ifdef MEM_TIMEOUT_EN
              cnt_d    = '0;
`endif
            end
          end
        end
      end
      ST_WAIT: begin
        if (mem.mem_ready) begin
          req_d = 1'b0;
          if (!stall_in) begin
            result_d = fmt;
            rd_out_d = rd_cap_q;
            valid_d  = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            buf_d   = fmt;
            state_d = ST_HOLD;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Watchdog expiry; reported only once downstream can take it
          if (!stall_in) begin
            req_d    = 1'b0;
            result_d = '0;
            rd_out_d = 5'd0;
            valid_d  = 1'b1;
            berr_d   = 1'b1;
            state_d  = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_HOLD: begin
        if (!stall_in) begin
          result_d = buf_q;
          rd_out_d = rd_cap_q;
          valid_d  = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE; req_q <= 1'b0; we_q <= 1'b0;
      addr_q <= '0; be_q <= '0; wdata_q <= '0; f3_q <= '0; off_q <= '0;
      rd_cap_q <= '0; buf_q <= '0; result_q <= '0; rd_out_q <= '0;
      valid_q <= 1'b0; mis_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q <= '0; berr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d; req_q <= req_d; we_q <= we_d;
      addr_q <= addr_d; be_q <= be_d; wdata_q <= wdata_d; f3_q <= f3_d; off_q <= off_d;
      rd_cap_q <= rd_cap_d; buf_q <= buf_d; result_q <= result_d; rd_out_q <= rd_out_d;
      valid_q <= valid_d; mis_q <= mis_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q <= cnt_d; berr_q <= berr_d;
`endif
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;
  assign result        = result_q;
  assign rd_out        = rd_out_q;
  assign valid_out     = valid_q;
  assign misaligned    = mis_q;
`ifdef MEM_TIMEOUT_EN
  assign bus_error     = berr_q;
`endif
  // Upstream must hold unless this very edge completes the access
  assign stall_req = ((state_q == ST_WAIT) && !(mem.mem_ready && !stall_in)) ||
                     (state_q == ST_HOLD);

endmodule

// File: tb/tb_mem_access.sv
// Directed/randomised bench for mem_access with an expected-result queue.
module tb_mem_access;
  import mem_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall_in = 1'b0, valid_in = 1'b0, is_load = 1'b0, is_store = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addr = '0, store_data = '0;
  logic [4:0]  rd_in = '0;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        valid_out, misaligned, stall_req;
`ifdef MEM_TIMEOUT_EN
  logic        bus_error;
`endif

  int checks = 0;
  int errors = 0;
  // {misaligned, rd, result}
  logic [37:0] exp_q[$];

  mem_access_if mem_if ();

  mem_access #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .stall_in   (stall_in),
    .valid_in   (valid_in),
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .rd_in      (rd_in),
    .mem        (mem_if),
    .result     (result),
    .rd_out     (rd_out),
    .valid_out  (valid_out),
    .misaligned (misaligned),
`ifdef MEM_TIMEOUT_EN
    .bus_error  (bus_error),
`endif
    .stall_req  (stall_req)
  );

  // Clock
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent load formatting reference
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[8*off +: 8];
    h = d[16*off[1] +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return d;
    endcase
  endfunction

  // Scoreboard: compare every valid output against the queue head
  always @(negedge clock) begin
    if (!reset && valid_out) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {31'b0, valid_out}, 32'd0);
      end else begin
        logic [37:0] e;
        e = exp_q.pop_front();
        chk("rd_out", {27'b0, rd_out}, {27'b0, e[36:32]});
        chk("misaligned", {31'b0, misaligned}, {31'b0, e[37]});
        if (!e[37]) chk("result", result, e[31:0]);
      end
    end
  end

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd);
    valid_in = 1'b1; is_load = ld; is_store = st; funct3 = f3;
    addr = a; store_data = sd; rd_in = rd;
    @(posedge clock); #1;
    valid_in = 1'b0; is_load = 1'b0; is_store = 1'b0;
  endtask

  task automatic do_alu(input logic [31:0] a, input logic [4:0] rd);
    exp_q.push_back({1'b0, rd, a});
    drive(1'b0, 1'b0, 3'b000, a, 32'h0, rd);
  endtask

  task automatic do_mis(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [4:0] rd);
    exp_q.push_back({1'b1, 5'd0, 32'h0});
    drive(ld, st, f3, a, 32'h0, rd);
    @(negedge clock);
    chk("mis_no_req", {31'b0, mem_if.mem_req}, 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic do_mem(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                        input logic [31:0] rdata, input int waits,
                        input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] eres);
    logic [31:0] waddr;
    waddr = {a[31:2], 2'b00};
    exp_q.push_back({1'b0, rd, eres});
    drive(ld, st, f3, a, sd, rd);
    for (int i = 0; i < waits; i++) begin
      @(negedge clock);
      chk("wait_stall_req", {31'b0, stall_req}, 32'd1);
      chk("wait_mem_req", {31'b0, mem_if.mem_req}, 32'd1);
      @(posedge clock); #1;
    end
    @(negedge clock);
    chk("mem_req", {31'b0, mem_if.mem_req}, 32'd1);
    chk("mem_addr", mem_if.mem_addr, waddr);
    chk("mem_we", {31'b0, mem_if.mem_we}, {31'b0, st & ~ld});
    if (st && !ld) begin
      chk("mem_be", {28'b0, mem_if.mem_be}, {28'b0, ebe});
      chk("mem_wdata", mem_if.mem_wdata, ewd);
    end
    mem_if.mem_ready = 1'b1;
    mem_if.mem_rdata = rdata;
    #1;
    chk("ready_stall_req", {31'b0, stall_req}, 32'd0);
    @(posedge clock); #1;
    mem_if.mem_ready = 1'b0;
    mem_if.mem_rdata = $urandom;
    @(negedge clock);
    chk("done_mem_req", {31'b0, mem_if.mem_req}, 32'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    logic [2:0]  f3s[5];
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] rd_word;
    f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    mem_if.mem_ready = 1'b0;
    mem_if.mem_rdata = '0;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_valid_out", {31'b0, valid_out}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_if.mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_if.mem_we}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd_out", {27'b0, rd_out}, 32'd0);
    chk("rst_misaligned", {31'b0, misaligned}, 32'd0);
    chk("rst_mem_addr", mem_if.mem_addr, 32'd0);
    chk("rst_mem_be", {28'b0, mem_if.mem_be}, 32'd0);
    chk("rst_mem_wdata", mem_if.mem_wdata, 32'd0);
    chk("rst_stall_req", {31'b0, stall_req}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Non-memory pass-through, then a back-to-back burst
    do_alu(32'h0000_1234, 5'd5);
    @(negedge clock);
    chk("alu_mem_req", {31'b0, mem_if.mem_req}, 32'd0);
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) do_alu($urandom, 5'($urandom_range(1, 31)));
    @(posedge clock); #1;

    // Loads and stores
    do_mem(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd7, 32'h80AB_CDEF, 3, 4'h0, 32'h0, 32'hFFFF_FF80);
    do_mem(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_BEEF, 5'd0, 32'h0, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    do_mem(1'b0, 1'b1, 3'b000, 32'h003, 32'h0000_0055, 5'd0, 32'h0, 1, 4'b1000, 32'h5555_5555, 32'h0);
    do_mem(1'b0, 1'b1, 3'b010, 32'h010, 32'hDEAD_BEEF, 5'd0, 32'h0, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    do_mem(1'b1, 1'b0, 3'b001, 32'h006, 32'h0, 5'd2, 32'h8001_0000, 0, 4'h0, 32'h0, 32'hFFFF_8001);
    do_mem(1'b1, 1'b0, 3'b100, 32'h001, 32'h0, 5'd3, 32'h0000_9A00, 2, 4'h0, 32'h0, 32'h0000_009A);
    // Load and store both set behaves as a load
    do_mem(1'b1, 1'b1, 3'b010, 32'h020, 32'h1111, 5'd8, 32'hCAFE_F00D, 0, 4'h0, 32'h0, 32'hCAFE_F00D);

    // Misaligned accesses
    do_mis(1'b1, 1'b0, 3'b010, 32'h101, 5'd9);
    do_mis(1'b1, 1'b0, 3'b001, 32'h001, 5'd4);
    do_mis(1'b0, 1'b1, 3'b010, 32'h002, 5'd0);

    // Completion under downstream stall goes through HOLD
    exp_q.push_back({1'b0, 5'd3, 32'h0000_1234});
    drive(1'b1, 1'b0, 3'b101, 32'h002, 32'h0, 5'd3);
    stall_in = 1'b1;
    mem_if.mem_ready = 1'b1;
    mem_if.mem_rdata = 32'h1234_5678;
    @(negedge clock);
    chk("hold_entry_stall_req", {31'b0, stall_req}, 32'd1);
    @(posedge clock); #1;
    mem_if.mem_ready = 1'b0;
    @(negedge clock);
    chk("hold_stall_req", {31'b0, stall_req}, 32'd1);
    chk("hold_mem_req", {31'b0, mem_if.mem_req}, 32'd0);
    chk("hold_valid_out", {31'b0, valid_out}, 32'd0);
    @(posedge clock); #1;
    stall_in = 1'b0;
    @(negedge clock);
    chk("hold_exit_valid_out", {31'b0, valid_out}, 32'd0);
    @(posedge clock); #1;
    @(posedge clock); #1;

    // Random aligned loads
    for (int i = 0; i < 6; i++) begin
      f3 = f3s[$urandom_range(0, 4)];
      off = 2'($urandom_range(0, 3));
      if (f3[1:0] == 2'b01) off[0] = 1'b0;
      if (f3[1:0] == 2'b10) off = 2'b00;
      rd_word = $urandom;
      do_mem(1'b1, 1'b0, f3, {20'h0, 10'($urandom), off}, 32'h0, 5'($urandom_range(1, 31)),
             rd_word, $urandom_range(0, 2), 4'h0, 32'h0, model_load(f3, off, rd_word));
    end

    // Reset while WAIT, then a late ready that must be ignored
    drive(1'b1, 1'b0, 3'b010, 32'h040, 32'h0, 5'd4);
    @(negedge clock);
    chk("rstwait_mem_req", {31'b0, mem_if.mem_req}, 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    mem_if.mem_ready = 1'b1;
    @(negedge clock);
    chk("rstwait_req_dropped", {31'b0, mem_if.mem_req}, 32'd0);
    chk("rstwait_stall_req", {31'b0, stall_req}, 32'd0);
    @(posedge clock); #1;
    mem_if.mem_ready = 1'b0;
    @(negedge clock);
    chk("late_ready_valid_out", {31'b0, valid_out}, 32'd0);
    @(posedge clock); #1;

`ifdef MEM_TIMEOUT_EN
    // Watchdog: no ready for 4 WAIT cycles
    exp_q.push_back({1'b0, 5'd0, 32'h0});
    drive(1'b1, 1'b0, 3'b010, 32'h080, 32'h0, 5'd6);
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    chk("to_pending_bus_error", {31'b0, bus_error}, 32'd0);
    chk("to_pending_mem_req", {31'b0, mem_if.mem_req}, 32'd1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("to_bus_error", {31'b0, bus_error}, 32'd1);
    chk("to_mem_req", {31'b0, mem_if.mem_req}, 32'd0);
    @(posedge clock); #1;
`endif

    // Every expected result must have been produced
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("scoreboard_drain", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
